// File: rtl/ps2_receiver_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Error codes and state encoding are reused by the future host transmitter.
package ps2_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [1:0] PS2_ERR_NONE    = 2'd0;
  localparam logic [1:0] PS2_ERR_PARITY  = 2'd1;
  localparam logic [1:0] PS2_ERR_STOP    = 2'd2;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd3;

  // Odd parity over data plus parity bit: an odd count of ones is good.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_receiver_line_filter.sv
// Two-flop synchroniser plus stability filter for one open-collector PS/2 line.
// Flops preset to 1 so leaving reset on an idle bus never looks like a falling edge.
module ps2_receiver_line_filter #(
  parameter int unsigned FILT_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_filt
);

  localparam int unsigned CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_filt;

  // The filtered value moves only after FILT_LEN consecutive differing cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      if (r_sync[1] != r_filt) begin
        if (r_cnt == CW'(FILT_LEN - 1)) begin
          r_filt <= r_sync[1];
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device->host receiver: deframes 11-bit frames, checks parity/stop, and
// aborts frames whose clock stalls. Listen-only; never drives the bus.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | waiting for a clock fall with data low (start)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | next fall samples the parity bit
//   ST_STOP   | next fall samples the stop bit, emits byte/error
module ps2_receiver
  import ps2_receiver_pkg::*;
#(
  parameter int unsigned FILT_LEN      = 8,
  parameter int unsigned TIMEOUT_TICKS = 34
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sixus,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_dat_in,
  output logic [7:0] o_rx_dat,
  output logic       o_rx_stb,
  output logic       o_rx_err,
  output logic [1:0] o_rx_err_code
);

  logic w_filt_clk;
  logic w_filt_dat;
  logic w_fall;

  ps2_receiver_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_clk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_ps2_clk_in),
    .o_filt  (w_filt_clk)
  );

  ps2_receiver_line_filter #(.FILT_LEN(FILT_LEN)) u_filt_dat (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_line  (i_ps2_dat_in),
    .o_filt  (w_filt_dat)
  );

  rx_state_t  r_state,  w_state_nxt;
  logic       r_clk_prev;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift,  w_shift_nxt;
  logic       r_par,    w_par_nxt;
  logic [5:0] r_tmo,    w_tmo_nxt;
  logic [7:0] r_rx_dat, w_rx_dat_nxt;
  logic       r_rx_stb, w_rx_stb_nxt;
  logic       r_rx_err, w_rx_err_nxt;
  logic [1:0] r_code,   w_code_nxt;

  assign w_fall = r_clk_prev & ~w_filt_clk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_clk_prev <= 1'b1;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tmo      <= '0;
      r_rx_dat   <= '0;
      r_rx_stb   <= 1'b0;
      r_rx_err   <= 1'b0;
      r_code     <= PS2_ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_prev <= w_filt_clk;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_tmo      <= w_tmo_nxt;
      r_rx_dat   <= w_rx_dat_nxt;
      r_rx_stb   <= w_rx_stb_nxt;
      r_rx_err   <= w_rx_err_nxt;
      r_code     <= w_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_tmo_nxt    = (r_state == ST_IDLE) ? 6'd0 : r_tmo;
    w_rx_dat_nxt = r_rx_dat;
    w_rx_stb_nxt = 1'b0;
    w_rx_err_nxt = 1'b0;
    w_code_nxt   = r_code;

    // A clock fall takes priority over a coincident timeout tick.
    if (w_fall) begin
      w_tmo_nxt = 6'd0;
      unique case (r_state)
        ST_IDLE: begin
          if (!w_filt_dat) begin
            w_state_nxt  = ST_DATA;
            w_bitcnt_nxt = 3'd0;
          end
        end
        ST_DATA: begin
          w_shift_nxt  = {w_filt_dat, r_shift[7:1]};
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_nxt   = w_filt_dat;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          w_state_nxt = ST_IDLE;
          if (!w_filt_dat) begin
            w_rx_err_nxt = 1'b1;
            w_code_nxt   = PS2_ERR_STOP;
          end else if (odd_parity_ok(r_shift, r_par)) begin
            w_rx_stb_nxt = 1'b1;
            w_rx_dat_nxt = r_shift;
          end else begin
            w_rx_err_nxt = 1'b1;
            w_code_nxt   = PS2_ERR_PARITY;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (i_sixus && (r_state != ST_IDLE)) begin
      if (r_tmo == 6'(TIMEOUT_TICKS - 1)) begin
        w_tmo_nxt    = 6'd0;
        w_state_nxt  = ST_IDLE;
        w_rx_err_nxt = 1'b1;
        w_code_nxt   = PS2_ERR_TIMEOUT;
      end else begin
        w_tmo_nxt = r_tmo + 6'd1;
      end
    end
  end

  assign o_rx_dat      = r_rx_dat;
  assign o_rx_stb      = r_rx_stb;
  assign o_rx_err      = r_rx_err;
  assign o_rx_err_code = r_code;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver with a time-scaled PS/2 device model:
// one system clock stands for 1us, so the 80us PS/2 period is 80 cycles and sixus every 6.
module tb_ps2_receiver;

  localparam int H = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       six_auto = 1'b0;
  logic       six_man = 1'b0;
  logic       auto_en = 1'b1;
  logic       sixus;
  logic [7:0] o_rx_dat;
  logic       o_rx_stb;
  logic       o_rx_err;
  logic [1:0] o_rx_err_code;

  int total = 0;
  int fails = 0;
  int six_div = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int width_bad = 0;
  int both_bad = 0;
  int last_dat = 0;
  int last_code = 0;
  logic prev_stb = 1'b0;
  logic prev_err = 1'b0;
  int s0, e0;

  assign sixus = six_auto | six_man;

  ps2_receiver dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sixus       (sixus),
    .i_ps2_clk_in  (ps2_clk),
    .i_ps2_dat_in  (ps2_dat),
    .o_rx_dat      (o_rx_dat),
    .o_rx_stb      (o_rx_stb),
    .o_rx_err      (o_rx_err),
    .o_rx_err_code (o_rx_err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (six_div == 5) begin
      six_div  <= 0;
      six_auto <= auto_en;
    end else begin
      six_div  <= six_div + 1;
      six_auto <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (o_rx_stb) begin
      stb_cnt++;
      last_dat = int'(o_rx_dat);
      if (prev_stb) width_bad++;
    end
    if (o_rx_err) begin
      err_cnt++;
      last_code = int'(o_rx_err_code);
      if (prev_err) width_bad++;
    end
    if (o_rx_stb && o_rx_err) both_bad++;
    prev_stb = o_rx_stb;
    prev_err = o_rx_err;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data changes mid-high; glitch adds a FILT_LEN-1 cycle clock low pulse in the high phase.
  task automatic send_bit(input logic b, input bit glitch);
    wait_cyc(H / 2);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(5);
      ps2_clk = 1'b0;
      wait_cyc(7);
      ps2_clk = 1'b1;
      wait_cyc(H / 2 - 12);
    end else begin
      wait_cyc(H / 2);
    end
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input int nbits, input int glitch_bit);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_bit);
    wait_cyc(H / 2);
    ps2_dat = 1'b1;
    wait_cyc(H);
  endtask

  task automatic snap();
    s0 = stb_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    wait_cyc(3);
    check("reset_rx_dat", int'(o_rx_dat), 0);
    check("reset_rx_stb", int'(o_rx_stb), 0);
    check("reset_rx_err", int'(o_rx_err), 0);
    check("reset_err_code", int'(o_rx_err_code), 0);
    rst_n = 1'b1;
    wait_cyc(20);

    // 1: good 0x1C
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, -1);
    check("t1_stb_count", stb_cnt - s0, 1);
    check("t1_err_count", err_cnt - e0, 0);
    check("t1_rx_dat", int'(o_rx_dat), 'h1C);

    // 2: 0xF0 with bad parity
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 11, -1);
    check("t2_err_count", err_cnt - e0, 1);
    check("t2_err_code", last_code, 1);
    check("t2_stb_count", stb_cnt - s0, 0);
    check("t2_rx_dat_held", int'(o_rx_dat), 'h1C);
    check("t2_code_held", int'(o_rx_err_code), 1);

    // 3: stop error then the same byte framed correctly
    snap();
    send_frame(8'h5A, 1'b1, 1'b0, 11, -1);
    check("t3_err_count", err_cnt - e0, 1);
    check("t3_err_code", last_code, 2);
    snap();
    send_frame(8'h5A, 1'b1, 1'b1, 11, -1);
    check("t3_stb_count", stb_cnt - s0, 1);
    check("t3_err_none", err_cnt - e0, 0);
    check("t3_rx_dat", int'(o_rx_dat), 'h5A);
    // bad parity and bad stop together report the stop error
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
    check("t3_stop_wins_code", last_code, 2);
    check("t3_stop_wins_stb", stb_cnt - s0, 0);

    // 4: clock stalls after 5 data bits, timeout on the 34th tick
    auto_en = 1'b0;
    wait_cyc(8);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 6, -1);
    wait_cyc(10);
    for (int t = 0; t < 33; t++) begin
      six_man = 1'b1;
      wait_cyc(1);
      six_man = 1'b0;
      wait_cyc(2);
    end
    check("t4_no_err_before_34", err_cnt - e0, 0);
    six_man = 1'b1;
    wait_cyc(1);
    six_man = 1'b0;
    wait_cyc(3);
    check("t4_err_count", err_cnt - e0, 1);
    check("t4_err_code", last_code, 3);
    auto_en = 1'b1;
    wait_cyc(10);
    snap();
    send_frame(8'h29, 1'b0, 1'b1, 11, -1);
    check("t4_stb_count", stb_cnt - s0, 1);
    check("t4_err_none", err_cnt - e0, 0);
    check("t4_rx_dat", int'(o_rx_dat), 'h29);

    // 5: short clock pulses ignored; idle data-low pulse ignored
    snap();
    ps2_dat = 1'b0;
    wait_cyc(2);
    ps2_clk = 1'b0;
    wait_cyc(7);
    ps2_clk = 1'b1;
    wait_cyc(5);
    ps2_dat = 1'b1;
    wait_cyc(300);
    check("t5_idle_glitch_err", err_cnt - e0, 0);
    check("t5_idle_glitch_stb", stb_cnt - s0, 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 3);
    check("t5_glitch_frame_stb", stb_cnt - s0, 1);
    check("t5_glitch_frame_dat", int'(o_rx_dat), 'h1C);
    snap();
    ps2_dat = 1'b0;
    wait_cyc(100);
    ps2_dat = 1'b1;
    wait_cyc(300);
    check("t5_dat_pulse_stb", stb_cnt - s0, 0);
    check("t5_dat_pulse_err", err_cnt - e0, 0);

    // 6: asynchronous reset mid-DATA, then a clean frame
    send_frame(8'h76, 1'b0, 1'b1, 4, -1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async_rx_dat", int'(o_rx_dat), 0);
    check("t6_async_err_code", int'(o_rx_err_code), 0);
    wait_cyc(3);
    check("t6_rx_stb_low", int'(o_rx_stb), 0);
    check("t6_rx_err_low", int'(o_rx_err), 0);
    rst_n = 1'b1;
    wait_cyc(20);
    snap();
    send_frame(8'h76, 1'b0, 1'b1, 11, -1);
    check("t6_stb_count", stb_cnt - s0, 1);
    check("t6_err_none", err_cnt - e0, 0);
    check("t6_rx_dat", int'(o_rx_dat), 'h76);

    check("pulse_width_one_cycle", width_bad, 0);
    check("stb_err_exclusive", both_bad, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
